// File: rtl/if_id_hazard_ctrl.sv
// IF/ID stall/flush sequencer for the 2-way in-order core: mispredict > mul/div busy > load-use.
// Optional HAZ_PERF_CNT_EN adds saturating stall/flush/md-wait performance counters.
module if_id_hazard_ctrl #(
    parameter int unsigned LU_STALL_CYC = 1,
    parameter int unsigned RECOVER_CYC  = 1,
    parameter int unsigned MD_TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        mispredict_EX,
    input  logic        load_use_w0,
    input  logic        load_use_w1,
    input  logic        md_start,
    input  logic        md_done,
    output logic        IF_ID_write,
    output logic        Flush,
    output logic        PC_write,
    output logic        ID_EX_bubble,
    output logic        EX_hold,
    output logic [1:0]  ctrl_state,
    output logic        md_timeout
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_md_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MD_WAIT  = 2'd2,
        RECOVER  = 2'd3
    } state_e;

    // The first load-use cycle is spent in RUN, hence the -2 preload.
    localparam logic [2:0] LU_INIT  = (LU_STALL_CYC > 1) ? 3'(LU_STALL_CYC - 2) : 3'd0;
    localparam logic [2:0] REC_INIT = (RECOVER_CYC > 0) ? 3'(RECOVER_CYC - 1) : 3'd0;
    localparam logic [7:0] MD_LAST  = 8'(MD_TIMEOUT - 1);
    localparam bit         LU_MULTI = (LU_STALL_CYC > 1);
    localparam bit         REC_EN   = (RECOVER_CYC > 0);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] md_cnt_q, md_cnt_d;
    logic       timeout_q, timeout_d;

    logic       lu_any;
    logic       stall_cyc;
    logic       flush_cyc;
    logic       md_cyc;

    assign lu_any = load_use_w0 | load_use_w1;

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q   <= RUN;
            cnt_q     <= 3'd0;
            md_cnt_q  <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            md_cnt_q  <= md_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        md_cnt_d     = md_cnt_q;
        timeout_d    = timeout_q;
        IF_ID_write  = 1'b1;
        PC_write     = 1'b1;
        Flush        = 1'b0;
        ID_EX_bubble = 1'b0;
        EX_hold      = 1'b0;
        stall_cyc    = 1'b0;
        flush_cyc    = 1'b0;
        md_cyc       = (state_q == MD_WAIT);

        if (mispredict_EX) begin
            IF_ID_write  = 1'b0;
            Flush        = 1'b1;
            ID_EX_bubble = 1'b1;
            flush_cyc    = 1'b1;
            md_cnt_d     = 8'd0;
            if (REC_EN) begin
                state_d = RECOVER;
                cnt_d   = REC_INIT;
            end else begin
                state_d = RUN;
                cnt_d   = 3'd0;
            end
        end else begin
            unique case (state_q)
                RUN: begin
                    if (md_start && !md_done) begin
                        state_d  = MD_WAIT;
                        md_cnt_d = 8'd0;
                    end else if (lu_any) begin
                        IF_ID_write  = 1'b0;
                        PC_write     = 1'b0;
                        ID_EX_bubble = 1'b1;
                        stall_cyc    = 1'b1;
                        if (LU_MULTI) begin
                            state_d = LU_STALL;
                            cnt_d   = LU_INIT;
                        end
                    end
                end
                LU_STALL: begin
                    IF_ID_write  = 1'b0;
                    PC_write     = 1'b0;
                    ID_EX_bubble = 1'b1;
                    stall_cyc    = 1'b1;
                    if (cnt_q == 3'd0) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                MD_WAIT: begin
                    if (md_done) begin
                        state_d  = RUN;
                        md_cnt_d = 8'd0;
                    end else begin
                        IF_ID_write = 1'b0;
                        PC_write    = 1'b0;
                        EX_hold     = 1'b1;
                        md_cnt_d    = md_cnt_q + 8'd1;
                        if (md_cnt_q == MD_LAST) begin
                            timeout_d = 1'b1;
                            state_d   = RUN;
                            md_cnt_d  = 8'd0;
                        end
                    end
                end
                RECOVER: begin
                    IF_ID_write  = 1'b0;
                    Flush        = 1'b1;
                    ID_EX_bubble = 1'b1;
                    flush_cyc    = 1'b1;
                    if (cnt_q == 3'd0) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = 3'd0;
                end
            endcase
        end

        // Reset forces a safe pipeline: flushed IF/ID, frozen PC.
        if (Reset) begin
            IF_ID_write  = 1'b0;
            PC_write     = 1'b0;
            Flush        = 1'b1;
            ID_EX_bubble = 1'b1;
            EX_hold      = 1'b0;
        end
    end

    assign ctrl_state = Reset ? RUN : state_q;
    assign md_timeout = timeout_q;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_flush_q, perf_md_q;

    always_ff @(posedge clk) begin
        if (Reset) begin
            perf_stall_q <= 32'd0;
            perf_flush_q <= 32'd0;
            perf_md_q    <= 32'd0;
        end else begin
            if (stall_cyc && (perf_stall_q != 32'hFFFF_FFFF)) perf_stall_q <= perf_stall_q + 32'd1;
            if (flush_cyc && (perf_flush_q != 32'hFFFF_FFFF)) perf_flush_q <= perf_flush_q + 32'd1;
            if (md_cyc && (perf_md_q != 32'hFFFF_FFFF))       perf_md_q    <= perf_md_q + 32'd1;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
    assign perf_md_cnt    = perf_md_q;
`else
    logic unused_perf;
    assign unused_perf = stall_cyc ^ flush_cyc ^ md_cyc;
`endif

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Directed bench: dut_a (LU=3, REC=2, TO=64) covers stall/flush/md paths, dut_b (LU=1, REC=1, TO=4) covers timeout.
module tb_if_id_hazard_ctrl;

    // {IF_ID_write, Flush, PC_write, ID_EX_bubble, EX_hold}
    localparam logic [4:0] O_NORM  = 5'b10100;
    localparam logic [4:0] O_STALL = 5'b00010;
    localparam logic [4:0] O_FLUSH = 5'b01110;
    localparam logic [4:0] O_HOLD  = 5'b00001;
    localparam logic [4:0] O_RST   = 5'b01010;

    logic clk;
    logic rst, mis, lu0, lu1, mds, mdd;
    logic ifid, flush, pcw, bub, hold, mto;
    logic [1:0] st;
    logic b_rst, b_mis, b_lu0, b_lu1, b_mds, b_mdd;
    logic b_ifid, b_flush, b_pcw, b_bub, b_hold, b_mto;
    logic [1:0] b_st;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] ps, pf, pm, b_ps, b_pf, b_pm;
    logic [31:0] pf0;
`endif

    int total = 0;
    int bad   = 0;

    if_id_hazard_ctrl #(.LU_STALL_CYC(3), .RECOVER_CYC(2), .MD_TIMEOUT(64)) dut_a (
        .clk(clk), .Reset(rst), .mispredict_EX(mis), .load_use_w0(lu0), .load_use_w1(lu1),
        .md_start(mds), .md_done(mdd), .IF_ID_write(ifid), .Flush(flush), .PC_write(pcw),
        .ID_EX_bubble(bub), .EX_hold(hold), .ctrl_state(st), .md_timeout(mto)
`ifdef HAZ_PERF_CNT_EN
        , .perf_stall_cnt(ps), .perf_flush_cnt(pf), .perf_md_cnt(pm)
`endif
    );

    if_id_hazard_ctrl #(.LU_STALL_CYC(1), .RECOVER_CYC(1), .MD_TIMEOUT(4)) dut_b (
        .clk(clk), .Reset(b_rst), .mispredict_EX(b_mis), .load_use_w0(b_lu0), .load_use_w1(b_lu1),
        .md_start(b_mds), .md_done(b_mdd), .IF_ID_write(b_ifid), .Flush(b_flush), .PC_write(b_pcw),
        .ID_EX_bubble(b_bub), .EX_hold(b_hold), .ctrl_state(b_st), .md_timeout(b_mto)
`ifdef HAZ_PERF_CNT_EN
        , .perf_stall_cnt(b_ps), .perf_flush_cnt(b_pf), .perf_md_cnt(b_pm)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks A outputs+state, plus the Flush=>!IF_ID_write invariant.
    task automatic chk_a(input string tag, input logic [4:0] o, input logic [1:0] s);
        #1;
        chk(tag, {25'd0, ifid, flush, pcw, bub, hold, st}, {25'd0, o, s});
        chk({tag, "_inv"}, {31'd0, flush & ifid}, 32'd0);
    endtask

    task automatic chk_b(input string tag, input logic [4:0] o, input logic [1:0] s);
        #1;
        chk(tag, {25'd0, b_ifid, b_flush, b_pcw, b_bub, b_hold, b_st}, {25'd0, o, s});
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; mis = 1'b0; lu0 = 1'b0; lu1 = 1'b0; mds = 1'b0; mdd = 1'b0;
        b_rst = 1'b1; b_mis = 1'b0; b_lu0 = 1'b0; b_lu1 = 1'b0; b_mds = 1'b0; b_mdd = 1'b0;

        chk_a("rst_out", O_RST, 2'd0);
        chk_b("b_rst_out", O_RST, 2'd0);
        tick(); tick(); tick();
        rst = 1'b0; b_rst = 1'b0;
        chk_a("run_after_rst", O_NORM, 2'd0);
        chk("mto_after_rst", {31'd0, mto}, 32'd0);
        tick();

        // load-use, 3 stall cycles
        lu1 = 1'b1;
        chk_a("lu_c0", O_STALL, 2'd0);
        tick(); lu1 = 1'b0;
        chk_a("lu_c1", O_STALL, 2'd1);
        tick();
        chk_a("lu_c2", O_STALL, 2'd1);
        tick();
        chk_a("lu_done", O_NORM, 2'd0);
        tick();

        // mispredict during 2nd LU_STALL cycle
        lu0 = 1'b1; lu1 = 1'b1;
        chk_a("lu2_c0", O_STALL, 2'd0);
        tick(); lu0 = 1'b0; lu1 = 1'b0;
        chk_a("lu2_c1", O_STALL, 2'd1);
        tick(); mis = 1'b1;
        chk_a("mis_in_lu", O_FLUSH, 2'd1);
        tick(); mis = 1'b0;
        chk_a("rec_1", O_FLUSH, 2'd3);
        tick();
        chk_a("rec_2", O_FLUSH, 2'd3);
        tick();
        chk_a("rec_done", O_NORM, 2'd0);
        tick();

        // mul/div with done on the 6th cycle after start
        mds = 1'b1;
        chk_a("md_start", O_NORM, 2'd0);
        tick(); mds = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk_a("md_wait", O_HOLD, 2'd2);
            tick();
        end
        mdd = 1'b1;
        chk_a("md_done_cyc", O_NORM, 2'd2);
        tick(); mdd = 1'b0;
        chk_a("md_back_run", O_NORM, 2'd0);
        chk("mto_after_md", {31'd0, mto}, 32'd0);
        tick();

        // single-cycle op
        mds = 1'b1; mdd = 1'b1;
        chk_a("md_single", O_NORM, 2'd0);
        tick(); mds = 1'b0; mdd = 1'b0;
        chk_a("md_single_next", O_NORM, 2'd0);
        tick();

        // all three events together; md_start/load-use ignored in RECOVER
`ifdef HAZ_PERF_CNT_EN
        pf0 = pf;
`endif
        mis = 1'b1; mds = 1'b1; lu0 = 1'b1;
        chk_a("all3", O_FLUSH, 2'd0);
        tick(); mis = 1'b0; mds = 1'b0; lu0 = 1'b0;
        chk_a("all3_rec1", O_FLUSH, 2'd3);
        tick(); mds = 1'b1; lu0 = 1'b1;
        chk_a("all3_rec2_ign", O_FLUSH, 2'd3);
        tick(); mds = 1'b0; lu0 = 1'b0;
        chk_a("all3_run", O_NORM, 2'd0);
`ifdef HAZ_PERF_CNT_EN
        chk("perf_flush_delta", pf - pf0, 32'd3);
`endif
        tick();

        // mispredict abandons MD_WAIT
        mds = 1'b1;
        chk_a("md2_start", O_NORM, 2'd0);
        tick(); mds = 1'b0;
        chk_a("md2_wait", O_HOLD, 2'd2);
        tick(); mis = 1'b1;
        chk_a("md2_mis", O_FLUSH, 2'd2);
        tick(); mis = 1'b0;
        chk_a("md2_rec1", O_FLUSH, 2'd3);
        tick();
        chk_a("md2_rec2", O_FLUSH, 2'd3);
        tick();
        chk_a("md2_run", O_NORM, 2'd0);
        tick();

        // dut_b: LU_STALL_CYC=1 stays in RUN, RECOVER_CYC=1
        b_lu0 = 1'b1;
        chk_b("b_lu", O_STALL, 2'd0);
        tick(); b_lu0 = 1'b0;
        chk_b("b_lu_next", O_NORM, 2'd0);
        tick(); b_mis = 1'b1;
        chk_b("b_mis", O_FLUSH, 2'd0);
        tick(); b_mis = 1'b0;
        chk_b("b_rec", O_FLUSH, 2'd3);
        tick();
        chk_b("b_rec_done", O_NORM, 2'd0);
        tick();

        // dut_b: MD_TIMEOUT=4
        b_mds = 1'b1;
        chk_b("b_md_start", O_NORM, 2'd0);
        tick(); b_mds = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_b("b_md_wait", O_HOLD, 2'd2);
            chk("b_mto_pending", {31'd0, b_mto}, 32'd0);
            tick();
        end
        chk_b("b_to_run", O_NORM, 2'd0);
        chk("b_mto_set", {31'd0, b_mto}, 32'd1);
        tick(); b_mis = 1'b1;
        tick(); b_mis = 1'b0;
        tick(); tick();
        chk("b_mto_sticky", {31'd0, b_mto}, 32'd1);
        b_rst = 1'b1;
        tick(); b_rst = 1'b0;
        #1;
        chk("b_mto_cleared", {31'd0, b_mto}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
